// File: rtl/eth_frame_pkg.sv
// Shared types and constants for the Ethernet RX frame sequencer.
package eth_frame_pkg;

   localparam int unsigned WORD_W_DEF = 16;
   localparam int unsigned LAST_BIT   = 8;
   localparam int unsigned DATA_MSB   = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RECV,
      ST_DISCARD,
      ST_DRAIN,
      ST_DONE
   } state_e;

endpackage

// File: rtl/eth_frame_len_cnt.sv
// Saturating frame byte counter with synchronous clear and an at-limit compare.
module eth_frame_len_cnt #(
   parameter int unsigned LEN_W = 16,
   parameter int unsigned LIMIT = 1518
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [LEN_W-1:0] cnt_o,
   output logic             at_limit_c
);

   localparam logic [LEN_W-1:0] CNT_MAX  = '1;
   localparam logic [LEN_W-1:0] LIMIT_M1 = LEN_W'(LIMIT - 1);

   logic [LEN_W-1:0] cnt_q, cnt_d;

   // Clear has priority over counting; count sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + LEN_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o      = cnt_q;
   assign at_limit_c = (cnt_q == LIMIT_M1);

endmodule

// File: rtl/eth_frame_rx_ctrl.sv
// Ethernet RX frame sequencer: admits one frame per arm, drains, reports length.
// Optional truncation at MAX_FRAME_LEN when ETH_RX_LEN_LIMIT_EN is defined.
module eth_frame_rx_ctrl
   import eth_frame_pkg::*;
#(
   parameter int unsigned WORD_W        = WORD_W_DEF,
   parameter int unsigned LEN_W         = 16,
   parameter int unsigned FIFO_ELEM_W   = 11,
   parameter int unsigned MAX_FRAME_LEN = 1518
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   arm_i,
   input  logic                   abort_i,
   input  logic                   cont_i,
   input  logic [WORD_W-1:0]      src_data_i,
   input  logic                   src_valid_i,
   output logic                   src_ready_o,
   output logic [WORD_W-1:0]      dst_data_o,
   output logic                   dst_valid_o,
   input  logic                   dst_ready_i,
   input  logic [FIFO_ELEM_W-1:0] fifo_elements_i,
   output logic                   blocked_o,
   output logic                   frame_done_o,
   output logic [LEN_W-1:0]       frame_len_o,
   output logic [7:0]             frame_cnt_o,
   output logic                   trunc_o
);

   state_e           state_q, state_d;
   logic             len_clr, len_en, len_at_limit;
   logic [LEN_W-1:0] len_cnt;
   logic [LEN_W-1:0] frame_len_q, frame_len_d;
   logic [7:0]       frame_cnt_q, frame_cnt_d;
   logic             frame_done_q, frame_done_d;
   logic             src_ready_c, dst_valid_c;
   logic [WORD_W-1:0] dst_data_c;
   logic             src_last, xfer;
`ifdef ETH_RX_LEN_LIMIT_EN
   logic             trunc_flag_q, trunc_flag_d;
   logic             trunc_q, trunc_d;
`else
   logic             unused_at_limit;
   assign unused_at_limit = len_at_limit;
`endif

   assign src_last = src_data_i[LAST_BIT];
   assign xfer     = src_valid_i & dst_ready_i;

   eth_frame_len_cnt #(
      .LEN_W (LEN_W),
      .LIMIT (MAX_FRAME_LEN)
   ) u_len_cnt (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .clr_i      (len_clr),
      .en_i       (len_en),
      .cnt_o      (len_cnt),
      .at_limit_c (len_at_limit)
   );

   // Next-state, handshake steering and completion statistics.
   always_comb begin
      state_d      = state_q;
      len_clr      = 1'b0;
      len_en       = 1'b0;
      src_ready_c  = 1'b0;
      dst_valid_c  = 1'b0;
      dst_data_c   = {src_data_i[WORD_W-1:LAST_BIT], src_data_i[DATA_MSB:0]};
      frame_len_d  = frame_len_q;
      frame_cnt_d  = frame_cnt_q;
`ifdef ETH_RX_LEN_LIMIT_EN
      trunc_flag_d = trunc_flag_q;
      trunc_d      = trunc_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (arm_i) begin
               state_d = ST_RECV;
               len_clr = 1'b1;
`ifdef ETH_RX_LEN_LIMIT_EN
               trunc_flag_d = 1'b0;
`endif
            end
         end
         ST_RECV: begin
            src_ready_c = dst_ready_i;
            dst_valid_c = src_valid_i;
            len_en      = xfer;
            if (xfer && src_last) begin
               state_d = ST_DRAIN;
            end
`ifdef ETH_RX_LEN_LIMIT_EN
            // The word that reaches the limit goes out as the frame's last word.
            if (src_valid_i && !src_last && len_at_limit) begin
               dst_data_c[LAST_BIT] = 1'b1;
               if (dst_ready_i) begin
                  trunc_flag_d = 1'b1;
                  state_d      = ST_DISCARD;
               end
            end
`endif
         end
         ST_DISCARD: begin
`ifdef ETH_RX_LEN_LIMIT_EN
            src_ready_c = 1'b1;
            if (src_valid_i && src_last) begin
               state_d = ST_DRAIN;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         ST_DRAIN: begin
            if (fifo_elements_i == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            frame_len_d = len_cnt;
            frame_cnt_d = frame_cnt_q + 8'd1;
            len_clr     = 1'b1;
`ifdef ETH_RX_LEN_LIMIT_EN
            trunc_d      = trunc_flag_q;
            trunc_flag_d = 1'b0;
`endif
            state_d = cont_i ? ST_RECV : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort only redirects the sequencer; statistics already committed stay.
      if (abort_i) begin
         state_d = ST_IDLE;
         len_clr = 1'b1;
`ifdef ETH_RX_LEN_LIMIT_EN
         trunc_flag_d = 1'b0;
`endif
      end

      frame_done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q      <= ST_IDLE;
         frame_len_q  <= '0;
         frame_cnt_q  <= '0;
         frame_done_q <= 1'b0;
`ifdef ETH_RX_LEN_LIMIT_EN
         trunc_flag_q <= 1'b0;
         trunc_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         frame_len_q  <= frame_len_d;
         frame_cnt_q  <= frame_cnt_d;
         frame_done_q <= frame_done_d;
`ifdef ETH_RX_LEN_LIMIT_EN
         trunc_flag_q <= trunc_flag_d;
         trunc_q      <= trunc_d;
`endif
      end
   end

   assign src_ready_o  = src_ready_c;
   assign dst_valid_o  = dst_valid_c;
   assign dst_data_o   = dst_data_c;
   assign blocked_o    = !((state_q == ST_RECV) || (state_q == ST_DISCARD));
   assign frame_done_o = frame_done_q;
   assign frame_len_o  = frame_len_q;
   assign frame_cnt_o  = frame_cnt_q;
`ifdef ETH_RX_LEN_LIMIT_EN
   assign trunc_o      = trunc_q;
`else
   assign trunc_o      = 1'b0;
`endif

endmodule
